// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU request port, DMA request port and the
// single-port data memory side. The slave modport is the arbiter's view;
// the master modport is the view of the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output dma_ack, dma_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  dma_ack, dma_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data memory between the CPU data path
// and a DMA/loader port through an IDLE -> ISSUE -> RESP sequencer.
// Default build arbitrates round-robin on ties; defining DMEM_ARB_CPU_PRIO_EN
// gives the CPU fixed priority (DMA may starve).
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {PORT_CPU = 1'b0, PORT_DMA = 1'b1} port_t;

  state_t            state_q, state_d;
  port_t             win_q,   win_d;
  port_t             last_q,  last_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  port_t             pick;
  logic              cpu_ack_c;
  logic              dma_ack_c;

  // State and latched-request registers; async reset returns to IDLE with DMA as last grant
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      win_q   <= PORT_CPU;
      last_q  <= PORT_DMA;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Winner selection, request latching in IDLE and sequencer next state
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

`ifdef DMEM_ARB_CPU_PRIO_EN
    pick = bus.cpu_req ? PORT_CPU : PORT_DMA;
`else
    if (bus.cpu_req && bus.dma_req) begin
      pick = (last_q == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else begin
      pick = bus.cpu_req ? PORT_CPU : PORT_DMA;
    end
`endif

    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          win_d = pick;
          if (pick == PORT_CPU) begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end else begin
            we_d    = bus.dma_we;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; all zero outside their active state
  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_rdata = '0;
    bus.dma_rdata = '0;
    cpu_ack_c     = 1'b0;
    dma_ack_c     = 1'b0;

    case (state_q)
      ISSUE: begin
        bus.mem_re    = ~we_q;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
      end
      RESP: begin
        if (win_q == PORT_CPU) begin
          cpu_ack_c     = 1'b1;
          bus.cpu_rdata = we_q ? '0 : bus.mem_rdata;
        end else begin
          dma_ack_c     = 1'b1;
          bus.dma_rdata = we_q ? '0 : bus.mem_rdata;
        end
      end
      default: ;
    endcase

    bus.cpu_ack   = cpu_ack_c;
    bus.dma_ack   = dma_ack_c;
    bus.cpu_stall = bus.cpu_req & ~cpu_ack_c;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// synchronous memory on the memory side.
module tb_dmem_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural memory: captures on the edge ending the enable cycle
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge CLK) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Expected winners for three tied rounds starting from reset (0 = CPU, 1 = DMA)
`ifdef DMEM_ARB_CPU_PRIO_EN
  logic exp_win [3] = '{1'b0, 1'b0, 1'b0};
`else
  logic exp_win [3] = '{1'b0, 1'b1, 1'b0};
`endif

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h1111_0000 + i;
    bus.mem_rdata = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    RST = 1'b1;

    // Reset held for 3 cycles with cpu_req high
    repeat (3) begin
      nxt();
      chk1("rst_mem_re", bus.mem_re, 1'b0);
      chk1("rst_mem_we", bus.mem_we, 1'b0);
    end
    chk1("rst_cpu_ack", bus.cpu_ack, 1'b0);
    chk1("rst_dma_ack", bus.dma_ack, 1'b0);
    chkw("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chkw("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chkw("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chkw("rst_dma_rdata", bus.dma_rdata, 32'h0);
    chk1("rst_cpu_stall", bus.cpu_stall, 1'b1);
    bus.cpu_req = 1'b0;
    RST = 1'b0;

    // CPU store 0xDEADBEEF to 0x05
    nxt();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'h05; bus.cpu_wdata = 32'hDEADBEEF;
    #1 chk1("st_stall_idle", bus.cpu_stall, 1'b1);
    nxt();
    chk1("st_mem_we", bus.mem_we, 1'b1);
    chk1("st_mem_re", bus.mem_re, 1'b0);
    chkw("st_mem_addr", 32'(bus.mem_addr), 32'h05);
    chkw("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk1("st_ack_issue", bus.cpu_ack, 1'b0);
    nxt();
    chk1("st_ack", bus.cpu_ack, 1'b1);
    chkw("st_rdata", bus.cpu_rdata, 32'h0);
    chk1("st_stall_ack", bus.cpu_stall, 1'b0);
    chk1("st_mem_we_resp", bus.mem_we, 1'b0);

    // CPU load from 0x05 presented right after the ack
    nxt();
    bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
    chk1("ld_ack_idle", bus.cpu_ack, 1'b0);
    chk1("ld_mem_re_idle", bus.mem_re, 1'b0);
    nxt();
    chk1("ld_mem_re", bus.mem_re, 1'b1);
    chk1("ld_mem_we", bus.mem_we, 1'b0);
    chkw("ld_mem_addr", 32'(bus.mem_addr), 32'h05);
    nxt();
    chk1("ld_ack", bus.cpu_ack, 1'b1);
    chkw("ld_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chkw("ld_dma_rdata", bus.dma_rdata, 32'h0);
    nxt();
    bus.cpu_req = 1'b0;
    chk1("ld_ack_after", bus.cpu_ack, 1'b0);
    chkw("ld_rdata_after", bus.cpu_rdata, 32'h0);

    // Tied loads from reset: CPU 0x10, DMA 0x20, both held high
    RST = 1'b1;
    nxt();
    RST = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h10;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 7'h20;
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk1("tie_mem_re", bus.mem_re, 1'b1);
      chkw("tie_mem_addr", 32'(bus.mem_addr), exp_win[k] ? 32'h20 : 32'h10);
      nxt();
      chk1("tie_cpu_ack", bus.cpu_ack, ~exp_win[k]);
      chk1("tie_dma_ack", bus.dma_ack, exp_win[k]);
      chkw("tie_cpu_rdata", bus.cpu_rdata, exp_win[k] ? 32'h0 : 32'h1111_0010);
      chkw("tie_dma_rdata", bus.dma_rdata, exp_win[k] ? 32'h1111_0020 : 32'h0);
      nxt();
      chk1("tie_idle_acks", bus.cpu_ack | bus.dma_ack, 1'b0);
    end

`ifdef DMEM_ARB_CPU_PRIO_EN
    // Fixed priority: continuous CPU traffic starves DMA
    begin
      int dma_seen;
      dma_seen = 0;
      repeat (30) begin
        nxt();
        if (bus.dma_ack) dma_seen++;
      end
      chkw("prio_dma_starved", 32'(dma_seen), 32'h0);
    end
`endif
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;

    // Reset pulsed during ISSUE of a DMA store
    nxt();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 7'h40; bus.dma_wdata = 32'hCAFEF00D;
    nxt();
    chk1("rma_mem_we_issue", bus.mem_we, 1'b1);
    RST = 1'b1;
    #1;
    chk1("rma_mem_we_async", bus.mem_we, 1'b0);
    chk1("rma_mem_re_async", bus.mem_re, 1'b0);
    chk1("rma_dma_ack_async", bus.dma_ack, 1'b0);
    bus.dma_req = 1'b0;
    nxt();
    chk1("rma_dma_ack_rst", bus.dma_ack, 1'b0);
    RST = 1'b0;
    repeat (3) begin
      nxt();
      chk1("rma_dma_ack_after", bus.dma_ack, 1'b0);
      chk1("rma_mem_we_after", bus.mem_we, 1'b0);
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h05;
    nxt();
    chk1("rma_idle_issue_re", bus.mem_re, 1'b1);
    chkw("rma_idle_issue_addr", 32'(bus.mem_addr), 32'h05);
    nxt();
    chk1("rma_cpu_ack", bus.cpu_ack, 1'b1);
    chkw("rma_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    nxt();
    bus.cpu_req = 1'b0;

    // CPU load of 0x30 raised while a DMA store to 0x30 is in ISSUE
    nxt();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 7'h30; bus.dma_wdata = 32'h12345678;
    nxt();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h30;
    #1 chk1("stl_c1", bus.cpu_stall, 1'b1);
    nxt();
    chk1("stl_c2", bus.cpu_stall, 1'b1);
    chk1("stl_dma_ack", bus.dma_ack, 1'b1);
    chk1("stl_cpu_ack_c2", bus.cpu_ack, 1'b0);
    nxt();
    bus.dma_req = 1'b0;
    #1 chk1("stl_c3", bus.cpu_stall, 1'b1);
    nxt();
    chk1("stl_c4", bus.cpu_stall, 1'b1);
    chk1("stl_mem_re", bus.mem_re, 1'b1);
    chkw("stl_mem_addr", 32'(bus.mem_addr), 32'h30);
    nxt();
    chk1("stl_cpu_ack", bus.cpu_ack, 1'b1);
    chk1("stl_ack_stall", bus.cpu_stall, 1'b0);
    chkw("stl_cpu_rdata", bus.cpu_rdata, 32'h12345678);
    nxt();
    bus.cpu_req = 1'b0;
    #1 chk1("stl_after", bus.cpu_stall, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
